// File: rtl/contatore_decrementale_if.sv
// Control/status bundle of the down-counter: load/decrement requests in, state and flags out.
interface contatore_decrementale_if #(
    parameter int unsigned N = 2
);
    logic         in;
    logic         load;
    logic [N-1:0] load_value;
    logic [N-1:0] out;
    logic         zero;
    logic         borrow;

    modport master (
        output in, load, load_value,
        input  out, zero, borrow
    );

    modport slave (
        input  in, load, load_value,
        output out, zero, borrow
    );
endinterface

// File: rtl/contatore_decrementale.sv
// Moore down-counter with load, terminal-count flag and one-cycle underflow (borrow) pulse.
// WRAP selects modulo wrap-around or saturation at zero on underflow.
module contatore_decrementale #(
    parameter int unsigned N    = 2,
    parameter bit          WRAP = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    contatore_decrementale_if.slave bus
);
    localparam int unsigned W = N;

    logic [W-1:0] s_q;
    logic [W-1:0] s_new;
    logic         borrow_q;
    logic         borrow_new;
    logic         zero_q;

    // Next state: load beats decrement; underflow either wraps to all-ones or sticks at zero.
    always_comb begin
        s_new      = s_q;
        borrow_new = 1'b0;
        if (bus.load) begin
            s_new = bus.load_value;
        end else if (bus.in) begin
            if (s_q != '0) begin
                s_new = s_q - W'(1);
            end else begin
                borrow_new = 1'b1;
                s_new      = WRAP ? '1 : '0;
            end
        end
    end

    // zero is tracked as its own flop from s_new so every output comes straight off a register.
    always_ff @(posedge clock) begin
        if (reset) begin
            s_q      <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
        end else begin
            s_q      <= s_new;
            borrow_q <= borrow_new;
            zero_q   <= (s_new == '0);
        end
    end

    assign bus.out    = s_q;
    assign bus.zero   = zero_q;
    assign bus.borrow = borrow_q;
endmodule
